serial_frame_tx: RTL and testbench

Parametrised serial frame transmitter: accepts a parallel word over a valid/ready handshake and shifts out a start bit, the data bits, an optional parity bit and one or two stop bits on `TX`. Each bit is held for a programmable number of clocks. It is the next-generation transmit side of the serial transmission system. It replaces fixed 8-bit, one-bit-per-clock framing with configurable width, bit order, parity, stop length and bit period, plus flow control.

---
 rtl/serial_frame_tx.sv | 156 +++++++++++++++
 tb/tb_serial_frame_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits, optional parity, one or two stop bits,
// each bit held for CLKS_PER_BIT clocks, with a valid/ready word handshake.
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 1
) (
    input  logic              txclk,
    input  logic              rst,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic [DATA_W-1:0] d,
    output logic              TX,
    output logic              busy,
    output logic              frame_done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state, state_nxt;
    logic [TW-1:0]     timer, timer_nxt;
    logic [BW-1:0]     bitcnt, bitcnt_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [DATA_W-1:0] shifted;
    logic              par, par_nxt;
    logic              tx_nxt, busy_nxt, done_nxt;
    logic              timer_end;
    logic              accept;
    logic              first_bit;

    // Ready is gated by reset directly so an accept can never coincide with reset.
    assign d_ready   = (state == IDLE) && !rst;
    assign accept    = d_valid && d_ready;
    assign timer_end = (timer == TIMER_LAST);
    assign shifted   = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
    assign first_bit = (MSB_FIRST != 0) ? shreg[DATA_W-1] : shreg[0];

    always_ff @(posedge txclk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            TX         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            bitcnt     <= bitcnt_nxt;
            shreg      <= shreg_nxt;
            par        <= par_nxt;
            TX         <= tx_nxt;
            busy       <= busy_nxt;
            frame_done <= done_nxt;
        end
    end

    // TX is registered, so each branch loads the level of the bit that starts at this edge.
    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        bitcnt_nxt = bitcnt;
        shreg_nxt  = shreg;
        par_nxt    = par;
        tx_nxt     = TX;
        busy_nxt   = busy;
        done_nxt   = 1'b0;

        if (state != IDLE) begin
            timer_nxt = timer_end ? '0 : timer + 1'b1;
        end

        case (state)
            IDLE: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                if (accept) begin
                    shreg_nxt  = d;
                    par_nxt    = (PARITY_MODE == 1) ? ~^d : ^d;
                    timer_nxt  = '0;
                    bitcnt_nxt = '0;
                    tx_nxt     = 1'b0;
                    busy_nxt   = 1'b1;
                    state_nxt  = START;
                end
            end
            START: begin
                if (timer_end) begin
                    tx_nxt     = first_bit;
                    bitcnt_nxt = '0;
                    state_nxt  = DATA;
                end
            end
            DATA: begin
                if (timer_end) begin
                    if (bitcnt == DATA_LAST) begin
                        bitcnt_nxt = '0;
                        if (PARITY_MODE != 0) begin
                            tx_nxt    = par;
                            state_nxt = PARITY;
                        end else begin
                            tx_nxt    = 1'b1;
                            state_nxt = STOP;
                        end
                    end else begin
                        shreg_nxt  = shifted;
                        tx_nxt     = (MSB_FIRST != 0) ? shifted[DATA_W-1] : shifted[0];
                        bitcnt_nxt = bitcnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (timer_end) begin
                    tx_nxt     = 1'b1;
                    bitcnt_nxt = '0;
                    state_nxt  = STOP;
                end
            end
            STOP: begin
                tx_nxt = 1'b1;
                if (timer_end) begin
                    if (bitcnt == STOP_LAST) begin
                        bitcnt_nxt = '0;
                        busy_nxt   = 1'b0;
                        done_nxt   = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        bitcnt_nxt = bitcnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three differently configured instances share clock and reset,
// driven from a constant vector table, hand-written reset sequences and random words.
module tb_serial_frame_tx;

    logic        txclk;
    logic        rst;
    logic [2:0]  dv;
    logic [31:0] dd [3];
    logic [2:0]  rdyv;
    logic [2:0]  txv;
    logic [2:0]  busyv;
    logic [2:0]  donev;

    int vectors;
    int miscompares;

    // Unit 0: 8 bits, odd parity, 1 stop, MSB first, 4 clocks/bit.
    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1), .MSB_FIRST(1)) ua (
        .txclk(txclk), .rst(rst), .d_valid(dv[0]), .d_ready(rdyv[0]), .d(dd[0][7:0]),
        .TX(txv[0]), .busy(busyv[0]), .frame_done(donev[0]));

    // Unit 1: 8 bits, even parity, 2 stops, LSB first, 3 clocks/bit.
    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(3), .PARITY_MODE(2), .STOP_BITS(2), .MSB_FIRST(0)) ub (
        .txclk(txclk), .rst(rst), .d_valid(dv[1]), .d_ready(rdyv[1]), .d(dd[1][7:0]),
        .TX(txv[1]), .busy(busyv[1]), .frame_done(donev[1]));

    // Unit 2: 5 bits, no parity, 1 stop, MSB first, 1 clock/bit.
    serial_frame_tx #(.DATA_W(5), .CLKS_PER_BIT(1), .PARITY_MODE(0), .STOP_BITS(1), .MSB_FIRST(1)) uc (
        .txclk(txclk), .rst(rst), .d_valid(dv[2]), .d_ready(rdyv[2]), .d(dd[2][4:0]),
        .TX(txv[2]), .busy(busyv[2]), .frame_done(donev[2]));

    initial txclk = 1'b0;
    always #5 txclk = ~txclk;

    typedef struct {
        int          unit;
        logic [31:0] data;
        logic [15:0] pat;
        int          n;
        bit          chainNext;
    } vec_t;

    vec_t tbl [5];

    function automatic int cfgW(input int u);
        case (u)
            0: return 8;
            1: return 8;
            default: return 5;
        endcase
    endfunction

    function automatic int cfgCpb(input int u);
        case (u)
            0: return 4;
            1: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int cfgPar(input int u);
        case (u)
            0: return 1;
            1: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int cfgStop(input int u);
        return (u == 1) ? 2 : 1;
    endfunction

    function automatic bit cfgMsb(input int u);
        return (u != 1);
    endfunction

    // Expected line levels, one entry per bit period, built from the framing rules.
    function automatic logic [63:0] modelFrame(input int u, input logic [31:0] data, output int n);
        logic [63:0] e;
        int          w;
        int          ones;
        e    = '1;
        w    = cfgW(u);
        n    = 0;
        ones = 0;
        e[n] = 1'b0;
        n++;
        for (int i = 0; i < w; i++) begin
            e[n] = cfgMsb(u) ? data[w-1-i] : data[i];
            ones += int'(e[n]);
            n++;
        end
        if (cfgPar(u) != 0) begin
            e[n] = (cfgPar(u) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            n++;
        end
        for (int i = 0; i < cfgStop(u); i++) begin
            e[n] = 1'b1;
            n++;
        end
        return e;
    endfunction

    function automatic logic [63:0] patToExp(input logic [15:0] pat, input int n);
        logic [63:0] e;
        e = '1;
        for (int i = 0; i < n; i++) e[i] = pat[n-1-i];
        return e;
    endfunction

    task automatic applyStimulus(input int u, input logic valid, input logic [31:0] data);
        dv[u] = valid;
        dd[u] = data;
    endtask

    task automatic checkOutput(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the gap cycle after frame_done.
    task automatic runFrame(input int u, input logic [31:0] data, input logic [63:0] expv, input int n,
                            input bit chained, input bit nextValid, input logic [31:0] nextData);
        int cpb;
        int total;
        cpb   = cfgCpb(u);
        total = n * cpb;
        if (!chained) begin
            checkOutput($sformatf("u%0d ready before accept", u), rdyv[u], 1'b1);
            applyStimulus(u, 1'b1, data);
        end
        @(negedge txclk);
        for (int c = 0; c < total; c++) begin
            checkOutput($sformatf("u%0d tx cycle %0d", u, c), txv[u], expv[c / cpb]);
            checkOutput($sformatf("u%0d busy cycle %0d", u, c), busyv[u], 1'b1);
            checkOutput($sformatf("u%0d done cycle %0d", u, c), donev[u], 1'b0);
            checkOutput($sformatf("u%0d ready cycle %0d", u, c), rdyv[u], 1'b0);
            if (c < total - 1) applyStimulus(u, 1'($urandom_range(0, 1)), $urandom);
            else applyStimulus(u, 1'b0, $urandom);
            @(negedge txclk);
        end
        checkOutput($sformatf("u%0d frame_done pulse", u), donev[u], 1'b1);
        checkOutput($sformatf("u%0d busy after frame", u), busyv[u], 1'b0);
        checkOutput($sformatf("u%0d tx gap", u), txv[u], 1'b1);
        checkOutput($sformatf("u%0d ready gap", u), rdyv[u], 1'b1);
        if (nextValid) applyStimulus(u, 1'b1, nextData);
        else applyStimulus(u, 1'b0, 32'h0);
    endtask

    task automatic checkIdleAll(input string tag, input logic expRdy);
        for (int u = 0; u < 3; u++) begin
            checkOutput($sformatf("%s u%0d tx", tag, u), txv[u], 1'b1);
            checkOutput($sformatf("%s u%0d busy", tag, u), busyv[u], 1'b0);
            checkOutput($sformatf("%s u%0d done", tag, u), donev[u], 1'b0);
            checkOutput($sformatf("%s u%0d ready", tag, u), rdyv[u], expRdy);
        end
    endtask

    initial begin
        logic [63:0] e;
        int          n;
        bit          prevChain;
        logic [31:0] rd, rd2;

        tbl[0] = '{unit: 0, data: 32'hA5, pat: 16'b00000_01010010111, n: 11, chainNext: 1'b0};
        tbl[1] = '{unit: 1, data: 32'h01, pat: 16'b0000_010000000111,  n: 12, chainNext: 1'b0};
        tbl[2] = '{unit: 0, data: 32'hFF, pat: 16'b00000_01111111111, n: 11, chainNext: 1'b1};
        tbl[3] = '{unit: 0, data: 32'h00, pat: 16'b00000_00000000011, n: 11, chainNext: 1'b0};
        tbl[4] = '{unit: 2, data: 32'h16, pat: 16'b000000000_0101101, n: 7,  chainNext: 1'b0};

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        for (int u = 0; u < 3; u++) applyStimulus(u, 1'b0, 32'h0);

        repeat (3) @(negedge txclk);
        checkIdleAll("reset", 1'b0);
        rst = 1'b0;
        #1;
        checkIdleAll("post-reset", 1'b1);
        @(negedge txclk);

        prevChain = 1'b0;
        for (int i = 0; i < 5; i++) begin
            runFrame(tbl[i].unit, tbl[i].data, patToExp(tbl[i].pat, tbl[i].n), tbl[i].n, prevChain,
                     tbl[i].chainNext, (i < 4) ? tbl[i+1].data : 32'h0);
            prevChain = tbl[i].chainNext;
        end

        // Reset at cycle 20 of a frame on unit 0 discards it without a frame_done.
        $display("[TB] reset mid-frame");
        e = modelFrame(0, 32'h5A, n);
        applyStimulus(0, 1'b1, 32'h5A);
        @(negedge txclk);
        applyStimulus(0, 1'b0, 32'h0);
        for (int c = 0; c < 20; c++) begin
            checkOutput($sformatf("abort tx cycle %0d", c), txv[0], e[c / 4]);
            @(negedge txclk);
        end
        rst = 1'b1;
        @(negedge txclk);
        checkIdleAll("abort", 1'b0);
        rst = 1'b0;
        repeat (4) begin
            @(negedge txclk);
            checkIdleAll("after abort", 1'b1);
        end

        // Reset and a valid word on the same edge: nothing is latched.
        rst = 1'b1;
        applyStimulus(0, 1'b1, 32'hC3);
        @(negedge txclk);
        rst = 1'b0;
        applyStimulus(0, 1'b0, 32'h0);
        #1;
        checkIdleAll("rst+accept", 1'b1);
        @(negedge txclk);
        checkIdleAll("rst+accept next", 1'b1);

        runFrame(0, 32'h3C, patToExp(16'b00000_00011110011, 11), 11, 1'b0, 1'b0, 32'h0);

        // Random words against the reference model, plus one random back-to-back pair.
        $display("[TB] random frames");
        for (int r = 0; r < 9; r++) begin
            int u;
            u  = r % 3;
            rd = $urandom & ((32'h1 << cfgW(u)) - 1);
            e  = modelFrame(u, rd, n);
            runFrame(u, rd, e, n, 1'b0, 1'b0, 32'h0);
        end
        rd  = $urandom & 32'hFF;
        rd2 = $urandom & 32'hFF;
        e   = modelFrame(1, rd, n);
        runFrame(1, rd, e, n, 1'b0, 1'b1, rd2);
        e   = modelFrame(1, rd2, n);
        runFrame(1, rd2, e, n, 1'b1, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
